flit_injector: RTL and testbench
================================

Name: flit_injector

Overview:
- Sits directly downstream of the test-vector input buffer. It accepts the buffer's data/valid stream and holds it in a small FIFO.
- Drives the buffer's active-low advance enable so the FIFO never overflows.
- Injects the buffered words as single-flit packets into the router's local input port under credit-based flow control.
- Gives the router port one clean registered interface, whatever rate the test source runs at.

Parameters:
- DATA_W, 8, flit width in bits; must match the input buffer's DATA_W.
- DEPTH, 4, FIFO entries; power of two, minimum 4.
- CREDITS, 4, router input-port buffer slots; initial and maximum credit count.
- STALL_MARGIN, 2, free FIFO entries kept in reserve to absorb the source's 2-cycle enable-to-valid loop; minimum 2.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous, active-low reset.
- in_data, input, DATA_W: word from the input buffer.
- in_valid, input, 1: in_data is valid this cycle.
- src_en, output, 1: enable to the input buffer. 0 = buffer advances, 1 = buffer holds. Registered.
- out_flit, output, DATA_W: flit to the router local port. Registered.
- out_valid, output, 1: out_flit is valid this cycle. Registered. Each assertion is exactly one flit.
- credit_in, input, 1: single-cycle pulse; the router freed one slot.
- fifo_count, output, $clog2(DEPTH+1): current FIFO occupancy.
- overflow, output, 1: sticky. Set when a word arrives while the FIFO is full.
- credit_err, output, 1: sticky. Set when credit_in arrives while credits == CREDITS.

Behaviour:
- Reset (rst_n low, asynchronous):
  - src_en=1, out_valid=0, out_flit=0, fifo_count=0, overflow=0, credit_err=0.
  - Credit counter = CREDITS; read and write pointers = 0.
  - Takes effect immediately, mid-operation included. FIFO contents are discarded.
  - First edge after rst_n rises: src_en re-evaluates to 0, since the FIFO is empty.
- FIFO: circular buffer with pointers of width $clog2(DEPTH). Pointers wrap DEPTH-1 -> 0.
- Write: at each edge where in_valid=1 and fifo_count<DEPTH, store in_data at the write pointer.
- Write while full: in_valid=1 and fifo_count==DEPTH drops the word and sets overflow. overflow stays set until reset.
- Send condition: fifo_count>0 and credits>0. When it holds at an edge:
  - out_flit <= head entry, out_valid <= 1.
  - Read pointer advances; credits decrement.
  - Otherwise out_valid <= 0 and out_flit holds its last value.
- Latency: a word written at edge N can appear on out_valid at edge N+1 at the earliest. There is no bypass.
- Simultaneous write and send: fifo_count is unchanged. This is allowed when full, since the send frees the slot first; the word is accepted, not dropped.
- Credits:
  - credit_in alone: +1.
  - Send alone: -1.
  - Both in the same cycle: unchanged.
  - credit_in at CREDITS with no send: saturates at CREDITS and sets credit_err.
  - When credits==0 and a credit_in arrives, sending resumes on the next edge.
- Source throttle: src_en <= (count_next >= DEPTH-STALL_MARGIN), where count_next is the post-edge occupancy. With STALL_MARGIN>=2, a conforming source never causes overflow.
- Sustained throughput: 1 flit/cycle when credits are available and the source is enabled.
- Controller states (implicit): IDLE (empty), STREAM (0<count<DEPTH), STALLED_SRC (src_en=1), BLOCKED (count>0, credits==0). No separate FSM register is required; the behaviour is fully defined by count and credits.

Test Plan:
- Reset then free-run: source vectors 0x11,0x22,0x33,0x44,0x55, credit_in pulsed one cycle after each out_valid.
  - src_en=0 one edge after reset release.
  - out_flit sequence 0x11..0x55, each out_valid one edge after its in_valid.
  - overflow=0 throughout.
- No credits returned: stream 8 words.
  - Exactly 4 flits sent (credits 4->0), then out_valid=0.
  - FIFO fills to 4; src_en=1 once count_next>=2.
  - overflow stays 0.
  - One credit_in pulse: exactly one further flit, on the next edge.
- Forced overflow: tie in_valid=1 ignoring src_en, credits held at 0.
  - The 5th word sets overflow=1 and is dropped; fifo_count stays 4.
  - overflow persists after the FIFO drains.
- Full FIFO with simultaneous write and send: fifo_count=4, credits=1, in_valid=1.
  - Flit sent; new word accepted; fifo_count remains 4; overflow=0.
- Credit edge cases:
  - credit_in and send in the same cycle: credits unchanged.
  - credit_in at credits=4 with no send: credit_err=1, credits stay 4.
- Async reset mid-stream: drop rst_n between clock edges with 3 words queued.
  - out_valid=0, fifo_count=0, src_en=1 immediately.
  - After release, the old words are never emitted and credits=4.

Source files
------------

// File: rtl/flit_injector.sv
// rtl/flit_injector.sv - buffers a test-vector stream and injects it as single-flit packets under credit flow control
//
// Purpose:
//    Sits between the test-vector input buffer and a router local input port.
//    Incoming words go into a small circular FIFO. The FIFO throttles the source
//    through src_en, and it drains one flit per cycle while the router has credits.
//    Every output is registered, so the router sees one clean interface.
//
// Ports:
//    clk         clock
//    rst_n       asynchronous active-low reset
//    in_data     word from the input buffer
//    in_valid    in_data valid this cycle
//    src_en      registered source enable; 0 = advance, 1 = hold
//    out_flit    registered flit to the router local port
//    out_valid   registered; one cycle high per flit
//    credit_in   single-cycle pulse; router freed one slot
//    fifo_count  current FIFO occupancy
//    overflow    sticky; a word arrived while the FIFO was full and no send freed a slot
//    credit_err  sticky; credit_in arrived with the counter already at CREDITS and no send

module flit_injector #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 4,
   parameter int CREDITS      = 4,
   parameter int STALL_MARGIN = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         src_en,
   output logic [DATA_W-1:0]            out_flit,
   output logic                         out_valid,
   input  logic                         credit_in,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         overflow,
   output logic                         credit_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int KW = $clog2(CREDITS+1);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] SRC_THRESH = CW'(DEPTH - STALL_MARGIN);
   localparam logic [KW-1:0] MAX_CRED   = KW'(CREDITS);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic [KW-1:0]     r_credits;
   logic              r_src_en;
   logic [DATA_W-1:0] r_out_flit;
   logic              r_out_valid;
   logic              r_overflow;
   logic              r_credit_err;

   logic              w_send;
   logic              w_full;
   logic              w_wr;
   logic              w_drop;
   logic              w_cred_sat;
   logic [CW-1:0]     w_count_next;
   logic [KW-1:0]     w_credits_next;

   assign w_send = (r_count != '0) && (r_credits != '0);
   assign w_full = (r_count == FULL_COUNT);
   // A send in the same cycle frees the head slot, so a full FIFO can still accept.
   assign w_wr   = in_valid && (!w_full || w_send);
   assign w_drop = in_valid && w_full && !w_send;
   // An extra credit is only an error when nothing is consuming one this cycle.
   assign w_cred_sat = credit_in && !w_send && (r_credits == MAX_CRED);

   always_comb begin
      w_count_next = r_count;
      if (w_wr && !w_send) begin
         w_count_next = r_count + CW'(1);
      end else if (!w_wr && w_send) begin
         w_count_next = r_count - CW'(1);
      end
   end

   always_comb begin
      w_credits_next = r_credits;
      if (credit_in && !w_send) begin
         if (r_credits != MAX_CRED) begin
            w_credits_next = r_credits + KW'(1);
         end
      end else if (!credit_in && w_send) begin
         w_credits_next = r_credits - KW'(1);
      end
   end

   // Storage has no reset: stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_credits    <= MAX_CRED;
         r_src_en     <= 1'b1;
         r_out_flit   <= '0;
         r_out_valid  <= 1'b0;
         r_overflow   <= 1'b0;
         r_credit_err <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_send) begin
            r_rptr     <= r_rptr + PW'(1);
            r_out_flit <= r_mem[r_rptr];
         end
         r_out_valid <= w_send;
         r_count     <= w_count_next;
         r_credits   <= w_credits_next;
         // Threshold on post-edge occupancy leaves STALL_MARGIN slots for words
         // already in flight around the source's enable-to-valid loop.
         r_src_en    <= (w_count_next >= SRC_THRESH);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_cred_sat) begin
            r_credit_err <= 1'b1;
         end
      end
   end

   assign src_en     = r_src_en;
   assign out_flit   = r_out_flit;
   assign out_valid  = r_out_valid;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign credit_err = r_credit_err;

endmodule

// File: tb/tb_flit_injector.sv
// tb/tb_flit_injector.sv - directed self-checking bench for flit_injector

module tb_flit_injector;

   localparam int DATA_W = 8;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              src_en;
   logic [DATA_W-1:0] out_flit;
   logic              out_valid;
   logic              credit_in;
   logic [2:0]        fifo_count;
   logic              overflow;
   logic              credit_err;

   int checks = 0;
   int errors = 0;
   int nflit;

   logic [7:0] v1 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
   logic [7:0] vd [4] = '{8'hA6, 8'hA7, 8'hB0, 8'hC0};

   flit_injector #(
      .DATA_W(8), .DEPTH(4), .CREDITS(4), .STALL_MARGIN(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .src_en     (src_en),
      .out_flit   (out_flit),
      .out_valid  (out_valid),
      .credit_in  (credit_in),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .credit_err (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      credit_in = 1'b0;

      // Reset values, applied asynchronously
      #2 rst_n = 1'b0;
      #1;
      chk("rst_src_en", src_en, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_flit", out_flit, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_credit_err", credit_err, 0);
      tick;
      tick;
      chk("rst_held_src_en", src_en, 1);
      rst_n = 1'b1;
      tick;
      chk("rel_src_en", src_en, 0);

      // Free run: 5 words back to back, a credit returned after each flit
      for (int e = 1; e <= 7; e++) begin
         in_valid  = (e <= 5);
         in_data   = (e <= 5) ? v1[e-1] : 8'h00;
         credit_in = (e >= 3);
         tick;
         chk("fr_out_valid", out_valid, (e >= 2 && e <= 6) ? 1 : 0);
         if (e >= 2 && e <= 6) chk("fr_out_flit", out_flit, v1[e-2]);
         chk("fr_overflow", overflow, 0);
         chk("fr_src_en", src_en, 0);
      end
      in_valid  = 1'b0;
      credit_in = 1'b0;
      chk("fr_credit_err", credit_err, 0);
      chk("fr_count_end", fifo_count, 0);

      // No credits returned: 8 words, 4 flits, FIFO fills to 4
      for (int e = 1; e <= 8; e++) begin
         in_valid = 1'b1;
         in_data  = 8'hA0 + 8'(e - 1);
         tick;
         chk("nc_out_valid", out_valid, (e >= 2 && e <= 5) ? 1 : 0);
         if (e >= 2 && e <= 5) chk("nc_out_flit", out_flit, 8'hA0 + 8'(e - 2));
         chk("nc_fifo_count", fifo_count, (e <= 5) ? 1 : e - 4);
         chk("nc_src_en", src_en, (e >= 6) ? 1 : 0);
         chk("nc_overflow", overflow, 0);
      end
      in_valid = 1'b0;
      tick;
      tick;
      chk("nc_blocked_valid", out_valid, 0);
      chk("nc_blocked_count", fifo_count, 4);
      chk("nc_flit_held", out_flit, 8'hA3);
      credit_in = 1'b1;
      tick;
      credit_in = 1'b0;
      chk("nc_credit_edge_valid", out_valid, 0);
      tick;
      chk("nc_resume_valid", out_valid, 1);
      chk("nc_resume_flit", out_flit, 8'hA4);
      chk("nc_resume_count", fifo_count, 3);
      chk("nc_resume_src_en", src_en, 1);
      tick;
      chk("nc_one_only", out_valid, 0);

      // Full FIFO with simultaneous write and send
      in_valid = 1'b1;
      in_data  = 8'hB0;
      tick;
      chk("fs_fill_count", fifo_count, 4);
      in_valid  = 1'b0;
      credit_in = 1'b1;
      tick;
      credit_in = 1'b0;
      chk("fs_pre_count", fifo_count, 4);
      in_valid = 1'b1;
      in_data  = 8'hC0;
      tick;
      chk("fs_out_valid", out_valid, 1);
      chk("fs_out_flit", out_flit, 8'hA5);
      chk("fs_count", fifo_count, 4);
      chk("fs_overflow", overflow, 0);

      // Forced overflow: in_valid held high, no credits
      in_data = 8'hD0;
      tick;
      chk("ov_set", overflow, 1);
      chk("ov_count", fifo_count, 4);
      chk("ov_out_valid", out_valid, 0);
      in_data = 8'hD1;
      tick;
      chk("ov_count2", fifo_count, 4);
      in_valid  = 1'b0;
      credit_in = 1'b1;
      tick;
      // Drain with credit_in and send coinciding: credits stay at 1
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i == 3) credit_in = 1'b0;
         chk("dr_out_valid", out_valid, 1);
         chk("dr_out_flit", out_flit, vd[i]);
      end
      chk("dr_count", fifo_count, 0);
      tick;
      chk("dr_idle_valid", out_valid, 0);
      chk("dr_overflow_sticky", overflow, 1);
      chk("dr_src_en", src_en, 0);

      // Credits back to CREDITS, then one too many
      credit_in = 1'b1;
      tick;
      tick;
      tick;
      credit_in = 1'b0;
      chk("ce_no_err", credit_err, 0);
      credit_in = 1'b1;
      tick;
      credit_in = 1'b0;
      chk("ce_err_set", credit_err, 1);
      tick;
      chk("ce_err_sticky", credit_err, 1);
      nflit = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid = (k < 5);
         in_data  = 8'hE0 + 8'(k);
         tick;
         if (out_valid) nflit++;
         if (k == 1) chk("ce_first_flit", out_flit, 8'hE0);
      end
      in_valid = 1'b0;
      chk("ce_flits_sent", nflit, 4);
      chk("ce_count", fifo_count, 1);

      // Async reset mid-stream with 3 words queued
      in_valid = 1'b1;
      in_data  = 8'hF0;
      tick;
      in_data  = 8'hF1;
      tick;
      in_valid = 1'b0;
      chk("ar_pre_count", fifo_count, 3);
      chk("ar_pre_src_en", src_en, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_count", fifo_count, 0);
      chk("ar_src_en", src_en, 1);
      chk("ar_overflow", overflow, 0);
      chk("ar_credit_err", credit_err, 0);
      #1 rst_n = 1'b1;
      tick;
      chk("ar_rel_src_en", src_en, 0);
      chk("ar_rel_valid", out_valid, 0);
      nflit = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid = (k < 5);
         in_data  = 8'h60 + 8'(k);
         tick;
         if (out_valid) begin
            chk("ar_new_flit", out_flit, 8'h60 + 8'(nflit));
            nflit++;
         end
      end
      in_valid = 1'b0;
      chk("ar_flits_sent", nflit, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
